// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] REG_PENDING = 3'd0;
   localparam logic [ADDR_W-1:0] REG_MASK    = 3'd1;
   localparam logic [ADDR_W-1:0] REG_CAUSE   = 3'd2;
   localparam logic [ADDR_W-1:0] REG_EPC     = 3'd3;
   localparam logic [ADDR_W-1:0] REG_ACK     = 3'd4;

   // PC address taken on interrupt entry
   localparam logic [DATA_W-1:0] IRQ_VECTOR = 32'h8000_0008;
   // ia bit that marks kernel space
   localparam int unsigned KERNEL_BIT = 31;

   // Width of a source index; at least one bit even for a single source
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned NSRC = 8
) (
   input  logic [NSRC-1:0]              req,
   output logic                         valid,
   output logic [idx_width(NSRC)-1:0]   idx
);

   localparam int unsigned IDXW = idx_width(NSRC);

   // Scan from the top so the lowest set index is the last one written
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = IDXW'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detected pending sources, mask, fixed priority,
// PC-vectoring capture of cause/EPC and a small register port.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned NSRC = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NSRC-1:0]    irq_src,
   input  logic [DATA_W-1:0]  ia,
   input  logic [DATA_W-1:0]  pcin,
   input  logic               stall,
   output logic               irq,
   input  logic [ADDR_W-1:0]  addr,
   input  logic               we,
   input  logic               re,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata
);

   localparam int unsigned IDXW = idx_width(NSRC);

   state_e              state_q, state_d;
   logic [NSRC-1:0]     prev_src_q, prev_src_d;
   logic [NSRC-1:0]     pending_q, pending_d;
   logic [NSRC-1:0]     mask_q, mask_d;
   logic [IDXW-1:0]     cause_q, cause_d;
   logic [DATA_W-1:0]   epc_q, epc_d;
   logic                irq_q, irq_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [NSRC-1:0]     active_c;
   logic [NSRC-1:0]     event_c;
   logic [NSRC-1:0]     clr_c;
   logic                win_valid_c;
   logic [IDXW-1:0]     win_idx_c;
   logic                accept_c;
   logic                wr_pending_c;
   logic                wr_mask_c;
   logic                wr_ack_c;
   logic [DATA_W-1:0]   rd_val_c;
   logic                unused_inputs_c;

   assign active_c     = pending_q & mask_q;
   assign event_c      = irq_src & ~prev_src_q;
   assign wr_pending_c = we && (addr == REG_PENDING);
   assign wr_mask_c    = we && (addr == REG_MASK);
   assign wr_ack_c     = we && (addr == REG_ACK);
   // Same condition the PC uses to take the vector this cycle
   assign accept_c     = irq_q & ~ia[KERNEL_BIT] & ~stall;

   // Only the kernel bit of ia and the source-wide slice of wdata matter
   assign unused_inputs_c = &{1'b0, ia[KERNEL_BIT-1:0], wdata[DATA_W-1:NSRC]};

   irq_prio_enc #(
      .NSRC (NSRC)
   ) u_prio (
      .req   (active_c),
      .valid (win_valid_c),
      .idx   (win_idx_c)
   );

   // Next-state, capture and pending update; new events always beat clears
   always_comb begin
      state_d    = state_q;
      prev_src_d = irq_src;
      mask_d     = mask_q;
      cause_d    = cause_q;
      epc_d      = epc_q;
      clr_c      = '0;

      if (wr_pending_c) clr_c = wdata[NSRC-1:0];
      if (wr_mask_c)    mask_d = wdata[NSRC-1:0];

      unique case (state_q)
         ST_IDLE: begin
            if (win_valid_c) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (!win_valid_c) begin
               state_d = ST_IDLE;
            end else if (accept_c) begin
               state_d = ST_SERVICE;
               cause_d = win_idx_c;
               epc_d   = pcin;
               clr_c   = clr_c | (NSRC'(1) << win_idx_c);
            end
         end
         ST_SERVICE: begin
            if (wr_ack_c) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      pending_d = (pending_q & ~clr_c) | event_c;
      irq_d     = (state_d == ST_REQ);
   end

   // Register read mux; sampled into rdata only when re is high
   always_comb begin
      rd_val_c = '0;
      unique case (addr)
         REG_PENDING: rd_val_c = DATA_W'(pending_q);
         REG_MASK:    rd_val_c = DATA_W'(mask_q);
         REG_CAUSE: begin
            rd_val_c[DATA_W-1] = (state_q == ST_SERVICE);
            rd_val_c[IDXW-1:0] = cause_q;
         end
         REG_EPC:     rd_val_c = epc_q;
         default:     rd_val_c = '0;
      endcase
      rdata_d = re ? rd_val_c : rdata_q;
   end

   // State and register flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         prev_src_q <= '0;
         pending_q  <= '0;
         mask_q     <= '0;
         cause_q    <= '0;
         epc_q      <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         prev_src_q <= prev_src_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
      end
   end

   assign irq   = irq_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios, a behavioural model
// compared every cycle, and literal expectations at key points.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   localparam int unsigned NSRC = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  irq_src;
   logic [31:0] ia, pcin, wdata;
   logic        stall, we, re;
   logic [2:0]  addr;
   logic        irq;
   logic [31:0] rdata;

   int n_checks = 0;
   int n_fail   = 0;

   irq_ctrl #(.NSRC(NSRC)) dut (
      .clk(clk), .reset(reset), .irq_src(irq_src), .ia(ia), .pcin(pcin),
      .stall(stall), .irq(irq), .addr(addr), .we(we), .re(re),
      .wdata(wdata), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  m_pending, m_mask, m_prev;
   bit          m_requesting, m_servicing;
   int          m_cause;
   logic [31:0] m_epc, m_rdata;
   bit          m_irq;
   logic [7:0]  m_act, m_ev, m_clr;
   int          m_win;

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return {24'h0, m_pending};
         3'd1: return {24'h0, m_mask};
         3'd2: return (m_servicing ? 32'h8000_0000 : 32'h0) | 32'(m_cause);
         3'd3: return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pending = 0; m_mask = 0; m_prev = 0; m_cause = 0; m_epc = 0;
         m_rdata = 0; m_irq = 0; m_requesting = 0; m_servicing = 0;
      end else begin
         m_act = m_pending & m_mask;
         m_win = lowest(m_act);
         if (re) m_rdata = model_read(addr);
         m_ev  = irq_src & ~m_prev;
         m_clr = (we && addr == 3'd0) ? wdata[7:0] : 8'h00;
         if (m_servicing) begin
            if (we && addr == 3'd4) m_servicing = 0;
         end else if (m_requesting) begin
            if (m_win < 0) begin
               m_requesting = 0;
            end else if (!ia[31] && !stall) begin
               m_requesting = 0;
               m_servicing  = 1;
               m_cause      = m_win;
               m_epc        = pcin;
               m_clr[m_win] = 1'b1;
            end
         end else if (m_win >= 0) begin
            m_requesting = 1;
         end
         if (we && addr == 3'd1) m_mask = wdata[7:0];
         m_pending = (m_pending & ~m_clr) | m_ev;
         m_prev    = irq_src;
         m_irq     = m_requesting;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (!reset) begin
         check("model_irq", {31'h0, irq}, {31'h0, m_irq});
         check("model_rdata", rdata, m_rdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      addr = a; re = 1'b1;
      tick();
      re = 1'b0;
      check(name, rdata, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; irq_src = 0; ia = 32'h0000_0100; pcin = 32'h0000_0104;
      stall = 0; we = 0; re = 0; addr = 0; wdata = 0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("reset_irq", {31'h0, irq}, 32'h0);
      for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, "reset_reg");

      // Single masked-in source, immediate accept
      wr(REG_MASK, 32'h04);
      irq_src = 8'h04; tick(); irq_src = 8'h00;
      check("t2_irq_before", {31'h0, irq}, 32'h0);
      tick();
      check("t2_irq_rise", {31'h0, irq}, 32'h1);
      tick();
      check("t2_irq_drop", {31'h0, irq}, 32'h0);
      ia = IRQ_VECTOR; pcin = IRQ_VECTOR + 32'd4;
      rd(REG_CAUSE, 32'h8000_0002, "t2_cause");
      rd(REG_EPC, 32'h0000_0104, "t2_epc");
      rd(REG_PENDING, 32'h0, "t2_pending");
      wr(REG_ACK, 32'h0);
      rd(REG_CAUSE, 32'h0000_0002, "t2_cause_ack");
      ia = 32'h0000_0100; pcin = 32'h0000_0104;

      // Two simultaneous sources: priority order
      wr(REG_MASK, 32'hFF);
      irq_src = 8'h22; tick(); irq_src = 8'h00;
      repeat (3) tick();
      rd(REG_CAUSE, 32'h8000_0001, "t3_cause_first");
      rd(REG_PENDING, 32'h20, "t3_pending_left");
      wr(REG_ACK, 32'h0);
      repeat (3) tick();
      rd(REG_CAUSE, 32'h8000_0005, "t3_cause_second");
      rd(REG_PENDING, 32'h0, "t3_pending_empty");
      wr(REG_ACK, 32'h0);

      // Stall and kernel-space hold off acceptance
      stall = 1'b1;
      irq_src = 8'h10; tick(); irq_src = 8'h00;
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         check("t4_stall_hold", {31'h0, irq}, 32'h1);
         tick();
      end
      stall = 1'b0; ia = 32'h8000_0010;
      for (int i = 0; i < 3; i++) begin
         check("t4_kernel_hold", {31'h0, irq}, 32'h1);
         tick();
      end
      rd(REG_EPC, 32'h0000_0104, "t4_epc_unchanged");
      ia = 32'h0000_0200; pcin = 32'h0000_0204;
      tick();
      check("t4_irq_drop", {31'h0, irq}, 32'h0);
      rd(REG_EPC, 32'h0000_0204, "t4_epc");
      rd(REG_CAUSE, 32'h8000_0004, "t4_cause");
      wr(REG_ACK, 32'h0);

      // Masked pending, unmask, then W1C withdraws the request
      stall = 1'b1;
      wr(REG_MASK, 32'h0);
      irq_src = 8'h08; tick(); irq_src = 8'h00;
      repeat (2) tick();
      check("t5_masked_irq", {31'h0, irq}, 32'h0);
      rd(REG_PENDING, 32'h08, "t5_pending");
      wr(REG_MASK, 32'h08);
      check("t5_unmask_wait", {31'h0, irq}, 32'h0);
      tick();
      check("t5_unmask_irq", {31'h0, irq}, 32'h1);
      wr(REG_PENDING, 32'h08);
      tick();
      check("t5_w1c_irq", {31'h0, irq}, 32'h0);
      rd(REG_PENDING, 32'h0, "t5_pending_clr");

      // Event and W1C of the same bit together: event wins
      irq_src = 8'h01; addr = REG_PENDING; wdata = 32'h01; we = 1'b1;
      tick();
      we = 1'b0; irq_src = 8'h00;
      rd(REG_PENDING, 32'h01, "t6_set_wins");

      // Read and write of MASK together returns the old value
      addr = REG_MASK; wdata = 32'h01; we = 1'b1; re = 1'b1;
      tick();
      we = 1'b0; re = 1'b0;
      check("t6_rw_old", rdata, 32'h08);
      rd(REG_MASK, 32'h01, "t6_mask_new");
      stall = 1'b0;
      repeat (2) tick();
      rd(REG_CAUSE, 32'h8000_0000, "t7_cause_src0");

      // Reset while in service clears everything
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      check("t7_reset_irq", {31'h0, irq}, 32'h0);
      rd(REG_CAUSE, 32'h0, "t7_reset_cause");
      rd(REG_EPC, 32'h0, "t7_reset_epc");
      rd(REG_MASK, 32'h0, "t7_reset_mask");
      rd(REG_PENDING, 32'h0, "t7_reset_pending");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
